mem_stage: RTL and testbench

Memory stage of the Y86 pipeline. It consumes the M-stage register contents (icode, valA, valP, valE, dstE, dstM) and runs any data-memory read or write over a request/acknowledge bus. It stalls the upstream stages while the access is outstanding and loads the memory→writeback (W) pipeline register. It also provides the memory-stage forwarding value (m_valM) to decode.

---
 rtl/mem_stage_pkg.sv | 37 +++
 rtl/mem_wb.sv | 45 ++++
 rtl/mem_stage.sv | 127 ++++++++++++
 tb/tb_mem_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared Y86 constants, memory-stage FSM states and icode classifiers.
// Imported by mem_stage and mem_wb.
package mem_stage_pkg;

  localparam int WORD   = 32;
  localparam int NIBBLE = 4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRMMOVL = 4'h4;
  localparam logic [3:0] IMRMOVL = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHL  = 4'hA;
  localparam logic [3:0] IPOPL   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } mem_state_e;

  function automatic logic is_read(input logic [3:0] ic);
    return (ic == IMRMOVL) || (ic == IPOPL) || (ic == IRET);
  endfunction

  function automatic logic is_write(input logic [3:0] ic);
    return (ic == IRMMOVL) || (ic == IPUSHL) || (ic == ICALL);
  endfunction

endpackage

// File: rtl/mem_wb.sv
// W pipeline register: loads on load=1, resets to a NOP bubble.
// valM has its own enable so non-reads keep the previous value.
module mem_wb
  import mem_stage_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_valm,
  input  logic [3:0]        d_icode,
  input  logic [WORD_W-1:0] d_valE,
  input  logic [WORD_W-1:0] d_valM,
  input  logic [3:0]        d_dstE,
  input  logic [3:0]        d_dstM,
  input  logic [2:0]        d_stat,
  output logic [3:0]        wb_icode,
  output logic [WORD_W-1:0] wb_valE,
  output logic [WORD_W-1:0] wb_valM,
  output logic [3:0]        wb_dstE,
  output logic [3:0]        wb_dstM,
  output logic [2:0]        wb_stat
);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_icode <= INOP;
      wb_valE  <= '0;
      wb_valM  <= '0;
      wb_dstE  <= RNONE;
      wb_dstM  <= RNONE;
      wb_stat  <= SAOK;
    end else if (load) begin
      wb_icode <= d_icode;
      wb_valE  <= d_valE;
      wb_dstE  <= d_dstE;
      wb_dstM  <= d_dstM;
      wb_stat  <= d_stat;
      if (load_valm)
        wb_valM <= d_valM;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Y86 memory stage: req/ack data-memory access FSM, stall, W register.
// Ports: M-stage inputs, dmem_* bus, m_stall, m_valM, wb_* outputs.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mem_icode,
  input  logic [WORD_W-1:0] mem_valA,
  input  logic [WORD_W-1:0] mem_valP,
  input  logic [WORD_W-1:0] mem_valE,
  input  logic [3:0]        mem_dstE,
  input  logic [3:0]        mem_dstM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic              dmem_err,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic              m_stall,
  output logic [WORD_W-1:0] m_valM,
  output logic [3:0]        wb_icode,
  output logic [WORD_W-1:0] wb_valE,
  output logic [WORD_W-1:0] wb_valM,
  output logic [3:0]        wb_dstE,
  output logic [3:0]        wb_dstM,
  output logic [2:0]        wb_stat
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  mem_state_e        state, state_d;
  logic [7:0]        timer;
  logic              err_flag;
  logic              rd, wr, need, timed_out;
  logic [WORD_W-1:0] addr_sel, wdata_sel;
  logic [2:0]        stat_d;

  always_comb begin
    rd        = is_read(mem_icode);
    wr        = is_write(mem_icode);
    need      = rd | wr;
    addr_sel  = (mem_icode == IPOPL || mem_icode == IRET)
              ? mem_valA : mem_valE;
    wdata_sel = (mem_icode == ICALL) ? mem_valP : mem_valA;
    // timer counts completed ACCESS cycles; this is the last allowed one
    timed_out = (timer >= TO_LAST);
    m_stall   = need & (state != S_DONE);
    if (err_flag && state == S_DONE)
      stat_d = SADR;
    else if (mem_icode == IHALT)
      stat_d = SHLT;
    else
      stat_d = SAOK;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:   if (need) state_d = S_ACCESS;
      S_ACCESS: if (dmem_ack || timed_out) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      m_valM     <= '0;
      timer      <= '0;
      err_flag   <= 1'b0;
    end else begin
      state <= state_d;
      unique case (state)
        S_IDLE: if (need) begin
          dmem_req   <= 1'b1;
          dmem_we    <= wr;
          dmem_addr  <= addr_sel;
          dmem_wdata <= wdata_sel;
          timer      <= '0;
          err_flag   <= 1'b0;
        end
        S_ACCESS: if (dmem_ack) begin
          dmem_req <= 1'b0;
          err_flag <= dmem_err;
          if (!dmem_we)
            m_valM <= dmem_rdata;
        end else if (timed_out) begin
          dmem_req <= 1'b0;
          err_flag <= 1'b1;
        end else if (timer != 8'hFF) begin
          timer <= timer + 8'd1;
        end
        default: ;
      endcase
    end
  end

  mem_wb #(.WORD_W(WORD_W)) u_wb (
    .clk       (clk),
    .rst       (rst),
    .load      (!m_stall),
    .load_valm (rd),
    .d_icode   (mem_icode),
    .d_valE    (mem_valE),
    .d_valM    (m_valM),
    .d_dstE    (mem_dstE),
    .d_dstM    (mem_dstM),
    .d_stat    (stat_d),
    .wb_icode  (wb_icode),
    .wb_valE   (wb_valE),
    .wb_valM   (wb_valM),
    .wb_dstE   (wb_dstE),
    .wb_dstM   (wb_dstM),
    .wb_stat   (wb_stat)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed plan steps plus random instructions
// checked against an instruction-level model of the stage.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 0;
  logic        rst = 1;
  logic [3:0]  mem_icode = 4'h1;
  logic [31:0] mem_valA = 0, mem_valP = 0, mem_valE = 0;
  logic [3:0]  mem_dstE = 4'hF, mem_dstM = 4'hF;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 0, dmem_err = 0;
  logic [31:0] dmem_rdata = 0;
  logic        m_stall;
  logic [31:0] m_valM;
  logic [3:0]  wb_icode, wb_dstE, wb_dstM;
  logic [31:0] wb_valE, wb_valM;
  logic [2:0]  wb_stat;

  int errs = 0;
  int checks = 0;
  logic [31:0] exp_valM = 0;
  logic [31:0] exp_wbvalM = 0;

  mem_stage #(.WORD_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_icode(mem_icode), .mem_valA(mem_valA),
    .mem_valP(mem_valP), .mem_valE(mem_valE),
    .mem_dstE(mem_dstE), .mem_dstM(mem_dstM),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_err(dmem_err),
    .dmem_rdata(dmem_rdata),
    .m_stall(m_stall), .m_valM(m_valM),
    .wb_icode(wb_icode), .wb_valE(wb_valE), .wb_valM(wb_valM),
    .wb_dstE(wb_dstE), .wb_dstM(wb_dstM), .wb_stat(wb_stat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction through M: ack after n ACCESS cycles (n > TO: none).
  task automatic run(input logic [3:0] ic, input logic [31:0] va,
                     input logic [31:0] vp, input logic [31:0] ve,
                     input logic [3:0] de, input logic [3:0] dm,
                     input int n, input logic err,
                     input logic [31:0] rdata);
    logic rd, wr, to;
    logic [31:0] ea, ewd;
    logic [2:0] est;
    int c;
    bit done;
    rd  = (ic == 4'h5) || (ic == 4'hB) || (ic == 4'h9);
    wr  = (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
    ea  = (ic == 4'hB || ic == 4'h9) ? va : ve;
    ewd = (ic == 4'h8) ? vp : va;
    to  = (n > TO);
    mem_icode = ic; mem_valA = va; mem_valP = vp;
    mem_valE = ve; mem_dstE = de; mem_dstM = dm;
    c = 0; done = 0;
    while (!done && c < 30) begin
      @(negedge clk);
      if (!m_stall) done = 1;
      else begin
        chk("req", {31'd0, dmem_req}, {31'd0, c > 0});
        if (c > 0) begin
          chk("addr", dmem_addr, ea);
          chk("we", {31'd0, dmem_we}, {31'd0, wr});
          if (wr) chk("wdata", dmem_wdata, ewd);
        end
        if (c == n) begin
          dmem_ack = 1; dmem_err = err; dmem_rdata = rdata;
        end
        @(posedge clk); #1;
        dmem_ack = 0; dmem_err = 0;
        c++;
      end
    end
    if (!done) chk("stall_timeout", 32'd1, 32'd0);
    chk("stall_cycles", c, (rd || wr) ? 1 + (to ? TO : n) : 0);
    if (rd && !to) exp_valM = rdata;
    chk("m_valM_done", m_valM, exp_valM);
    // stray ack while not in ACCESS must be ignored
    dmem_ack = 1; dmem_err = 1; dmem_rdata = ~rdata;
    @(posedge clk); #1;
    dmem_ack = 0; dmem_err = 0;
    if (rd) exp_wbvalM = exp_valM;
    if ((rd || wr) && (to || err)) est = 3'd3;
    else if (ic == 4'h0) est = 3'd2;
    else est = 3'd1;
    chk("wb_icode", wb_icode, ic);
    chk("wb_valE", wb_valE, ve);
    chk("wb_valM", wb_valM, exp_wbvalM);
    chk("wb_dstE", wb_dstE, de);
    chk("wb_dstM", wb_dstM, dm);
    chk("wb_stat", wb_stat, est);
    chk("m_valM_after", m_valM, exp_valM);
    chk("req_after", dmem_req, 1'b0);
  endtask

  initial begin
    logic [3:0] ic;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nop_stall", m_stall, 1'b0);
      chk("nop_req", dmem_req, 1'b0);
    end
    @(posedge clk); #1;
    chk("rst_wb_icode", wb_icode, 4'h1);
    chk("rst_wb_dstE", wb_dstE, 4'hF);
    chk("rst_wb_dstM", wb_dstM, 4'hF);
    chk("rst_wb_stat", wb_stat, 3'd1);
    chk("rst_m_valM", m_valM, 32'd0);

    run(4'h5, 0, 0, 32'h100, 4'hF, 4'h3, 1, 0, 32'hDEADBEEF);
    run(4'h8, 0, 32'h42, 32'h1FC, 4'h4, 4'hF, 4, 0, 32'h0);
    run(4'hB, 32'h200, 0, 32'h204, 4'h4, 4'h2, 1, 0, 32'h11);
    run(4'h9, 32'h1F0, 0, 32'h1F4, 4'h4, 4'hF, 2, 0, 32'h22);
    run(4'h4, 32'h77, 0, 32'h300, 4'hF, 4'hF, 1, 1, 32'h0);
    run(4'h4, 32'h78, 0, 32'h304, 4'hF, 4'hF, 10, 0, 32'h0);
    run(4'h5, 0, 0, 32'h308, 4'hF, 4'h1, 10, 0, 32'h99);
    run(4'h0, 0, 0, 0, 4'hF, 4'hF, 1, 0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      ic = 4'($urandom_range(0, 11));
      run(ic, $urandom, $urandom, $urandom,
          4'($urandom), 4'($urandom),
          $urandom_range(1, TO + 2), ($urandom_range(0, 3) == 0),
          $urandom);
    end

    mem_icode = 4'h5; mem_valE = 32'h400; mem_dstM = 4'h6;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_req", dmem_req, 1'b1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    mem_icode = 4'h1; mem_valE = 0; mem_valA = 0; mem_valP = 0;
    mem_dstE = 4'hF; mem_dstM = 4'hF;
    chk("rst_acc_req", dmem_req, 1'b0);
    chk("rst_acc_wb_icode", wb_icode, 4'h1);
    chk("rst_acc_wb_valM", wb_valM, 32'd0);
    chk("rst_acc_wb_dstM", wb_dstM, 4'hF);
    chk("rst_acc_wb_stat", wb_stat, 3'd1);
    chk("rst_acc_m_valM", m_valM, 32'd0);
    @(negedge clk);
    chk("rst_acc_stall", m_stall, 1'b0);
    dmem_ack = 1; dmem_err = 1; dmem_rdata = 32'h1234ABCD;
    @(posedge clk); #1;
    dmem_ack = 0; dmem_err = 0;
    chk("late_ack_m_valM", m_valM, 32'd0);
    chk("late_ack_req", dmem_req, 1'b0);
    chk("late_ack_wb_valM", wb_valM, 32'd0);
    chk("late_ack_wb_stat", wb_stat, 3'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
